// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the EX-stage ALU/MDU controller.
// Covers ALU operation codes, RV32M ops, ALUOp classes and Funct7 patterns.
package riscv_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_BLT  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_SLT  = 4'b1100,
        OP_SLTU = 4'b1101,
        OP_BLTU = 4'b1110,
        OP_BGEU = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_JL  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct3/Funct7 decoder producing the ALU operation code.
// Also classifies RV32M instructions and flags unrecognised encodings.
module alu_op_decode
    import riscv_alu_pkg::*;
#(
    parameter int unsigned MDU_EN = 1
) (
    input  logic [1:0] alu_op,
    input  logic       is_imm,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [3:0] operation,
    output logic       illegal,
    output logic       is_mdu,
    output logic       is_div
);

    alu_op_e op;
    logic    bad;
    logic    f7_base;
    logic    f7_alt;

    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);

    always_comb begin
        op     = OP_ADD;
        bad    = 1'b0;
        is_mdu = 1'b0;
        is_div = 1'b0;
        case (alu_op)
            ALUOP_BR: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            ALUOP_RI: begin
                if (!is_imm && funct7 == F7_MULDIV) begin
                    if (MDU_EN != 0) begin
                        is_mdu = 1'b1;
                        is_div = funct3[2];
                    end else begin
                        bad = 1'b1;
                    end
                end else begin
                    // Shifts check Funct7 even for I-type; other I-type ops carry immediate bits there.
                    case (funct3)
                        3'b000: begin
                            if (is_imm || f7_base) op = OP_ADD;
                            else if (f7_alt)       op = OP_SUB;
                            else                   bad = 1'b1;
                        end
                        3'b001: begin
                            if (f7_base) op = OP_SLL;
                            else         bad = 1'b1;
                        end
                        3'b101: begin
                            if (f7_base)     op = OP_SRL;
                            else if (f7_alt) op = OP_SRA;
                            else             bad = 1'b1;
                        end
                        default: begin
                            case (funct3)
                                3'b010:  op = OP_SLT;
                                3'b011:  op = OP_SLTU;
                                3'b100:  op = OP_XOR;
                                3'b110:  op = OP_OR;
                                default: op = OP_AND;
                            endcase
                            bad = !is_imm && !f7_base;
                        end
                    endcase
                end
            end
            default: op = OP_ADD;
        endcase
        if (bad) begin
            op     = OP_AND;
            is_mdu = 1'b0;
            is_div = 1'b0;
        end
    end

    assign operation = op;
    assign illegal   = bad;

endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU/MDU controller: ALU op decode plus issue/busy/done sequencing
// of a multi-cycle multiply/divide unit with pipeline stall generation.
module alu_mdu_controller
    import riscv_alu_pkg::*;
#(
    parameter int unsigned MDU_EN  = 1,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic       flush,
    input  logic [1:0] ALUOp,
    input  logic       IsImm,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    output logic [3:0] Operation,
    output logic       illegal,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       mdu_kill,
    output logic       mdu_done,
    output logic       result_sel,
    output logic       stall
);

    localparam int unsigned MAX_LAT = max_u(MUL_LAT, DIV_LAT);
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_L = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_L = CW'(DIV_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    mdu_op_e       op_q;

    logic enc_illegal;
    logic is_mdu;
    logic is_div;
    logic issue;
    logic busy;

    alu_op_decode #(
        .MDU_EN (MDU_EN)
    ) u_decode (
        .alu_op    (ALUOp),
        .is_imm    (IsImm),
        .funct7    (Funct7),
        .funct3    (Funct3),
        .operation (Operation),
        .illegal   (enc_illegal),
        .is_mdu    (is_mdu),
        .is_div    (is_div)
    );

    assign illegal = valid_in && enc_illegal;

    // Launch and stall are combinational so the issuing instruction is held in EX immediately.
    assign issue = !reset && (state == S_IDLE) && valid_in && is_mdu && !flush;
    assign busy  = !reset && (state == S_BUSY);

    assign mdu_start  = issue;
    assign mdu_kill   = busy && flush;
    assign stall      = issue || (busy && !flush);
    assign mdu_done   = !reset && (state == S_DONE);
    assign result_sel = mdu_done;
    assign mdu_op     = op_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= MDU_MUL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_q  <= mdu_op_e'(Funct3);
                        cnt   <= is_div ? DIV_L : MUL_L;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Self-checking bench for alu_mdu_controller: table-driven decode reference
// and cycle-timeline checks of MDU issue/busy/done/kill/reset behaviour.
module tb_alu_mdu_controller;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 33;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in, valid2, flush;
    logic [1:0] ALUOp;
    logic       IsImm;
    logic [6:0] Funct7;
    logic [2:0] Funct3;

    logic [3:0] op1, op2;
    logic       ill1, ill2, start1, start2, kill1, kill2, done1, done2, rsel1, rsel2, stall1, stall2;
    logic [2:0] mop1, mop2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mdu_controller #(.MDU_EN(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
        .ALUOp(ALUOp), .IsImm(IsImm), .Funct7(Funct7), .Funct3(Funct3),
        .Operation(op1), .illegal(ill1), .mdu_start(start1), .mdu_op(mop1),
        .mdu_kill(kill1), .mdu_done(done1), .result_sel(rsel1), .stall(stall1)
    );

    alu_mdu_controller #(.MDU_EN(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nomdu (
        .clk(clk), .reset(reset), .valid_in(valid2), .flush(flush),
        .ALUOp(ALUOp), .IsImm(IsImm), .Funct7(Funct7), .Funct3(Funct3),
        .Operation(op2), .illegal(ill2), .mdu_start(start2), .mdu_op(mop2),
        .mdu_kill(kill2), .mdu_done(done2), .result_sel(rsel2), .stall(stall2)
    );

    // Reference: list of every legal encoding; anything unmatched is illegal.
    typedef struct {
        logic [1:0] aluop;
        bit         imm_any;
        bit         imm;
        bit         f7_any;
        logic [6:0] f7;
        bit         f3_any;
        logic [2:0] f3;
        logic [3:0] op;
        bit         mdu;
    } enc_t;

    enc_t tbl[$];

    task automatic rule(input logic [1:0] a, input bit ia, input bit i, input bit f7a,
                        input logic [6:0] f7, input bit f3a, input logic [2:0] f3,
                        input logic [3:0] op, input bit mdu);
        enc_t e;
        e.aluop = a; e.imm_any = ia; e.imm = i; e.f7_any = f7a; e.f7 = f7;
        e.f3_any = f3a; e.f3 = f3; e.op = op; e.mdu = mdu;
        tbl.push_back(e);
    endtask

    function automatic void ref_decode(input logic [1:0] a, input logic i, input logic [6:0] f7,
                                       input logic [2:0] f3, input bit mdu_en,
                                       output logic [3:0] op, output bit bad);
        bad = 1'b1;
        op  = 4'b0000;
        foreach (tbl[k]) begin
            if (bad && tbl[k].aluop == a && (tbl[k].imm_any || tbl[k].imm == i) &&
                (tbl[k].f7_any || tbl[k].f7 == f7) && (tbl[k].f3_any || tbl[k].f3 == f3) &&
                !(tbl[k].mdu && !mdu_en)) begin
                bad = 1'b0;
                op  = tbl[k].op;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are driven there.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic i, input logic [6:0] f7,
                         input logic [2:0] f3, input logic v, input logic fl);
        ALUOp = a; IsImm = i; Funct7 = f7; Funct3 = f3; valid_in = v; flush = fl;
    endtask

    // One full MDU instruction from issue cycle T; kill_at=k>0 flushes on BUSY cycle k.
    task automatic mdu_run(input logic [2:0] f3, input int unsigned kill_at,
                           input bit flush_done, input bit hold_valid);
        int unsigned lat;
        lat = f3[2] ? DIV_LAT : MUL_LAT;
        cyc();
        drive(2'b10, 1'b0, 7'b0000001, f3, 1'b1, 1'b0);
        #2;
        check("issue_start", start1, 1);
        check("issue_stall", stall1, 1);
        check("issue_op_add", op1, 4'b0010);
        for (int unsigned k = 1; k <= lat; k++) begin
            cyc();
            valid_in = hold_valid;
            flush = (k == kill_at);
            #2;
            check("busy_mdu_op", mop1, f3);
            check("busy_done", done1, 0);
            check("busy_start", start1, 0);
            if (k == kill_at) begin
                check("kill_pulse", kill1, 1);
                check("kill_stall", stall1, 0);
                break;
            end
            check("busy_stall", stall1, 1);
            check("busy_kill", kill1, 0);
        end
        if (kill_at != 0) begin
            for (int unsigned k = 0; k < 3; k++) begin
                cyc();
                flush = 1'b0;
                valid_in = 1'b0;
                #2;
                check("post_kill_done", done1, 0);
                check("post_kill_kill", kill1, 0);
                check("post_kill_stall", stall1, 0);
            end
        end else begin
            cyc();
            flush = flush_done;
            #2;
            check("done", done1, 1);
            check("result_sel", rsel1, 1);
            check("done_stall", stall1, 0);
            check("done_kill", kill1, 0);
            check("done_no_restart", start1, 0);
            check("done_mdu_op", mop1, f3);
            if (!hold_valid) begin
                cyc();
                flush = 1'b0;
                valid_in = 1'b0;
                #2;
                check("after_done", done1, 0);
                check("after_done_stall", stall1, 0);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        logic [3:0] eop1, eop2;
        bit         ebad1, ebad2;
        logic [6:0] f7;
        int unsigned sel;

        // Memory/jump classes: ADD regardless of other fields.
        rule(2'b00, 1, 0, 1, 7'h0, 1, 3'b000, 4'b0010, 0);
        rule(2'b11, 1, 0, 1, 7'h0, 1, 3'b000, 4'b0010, 0);
        rule(2'b01, 1, 0, 1, 7'h0, 0, 3'b000, 4'b1000, 0);
        rule(2'b01, 1, 0, 1, 7'h0, 0, 3'b001, 4'b1001, 0);
        rule(2'b01, 1, 0, 1, 7'h0, 0, 3'b100, 4'b1010, 0);
        rule(2'b01, 1, 0, 1, 7'h0, 0, 3'b101, 4'b1011, 0);
        rule(2'b01, 1, 0, 1, 7'h0, 0, 3'b110, 4'b1110, 0);
        rule(2'b01, 1, 0, 1, 7'h0, 0, 3'b111, 4'b1111, 0);
        // R-type
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b000, 4'b0010, 0);
        rule(2'b10, 0, 0, 0, 7'b0100000, 0, 3'b000, 4'b0110, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b001, 4'b0100, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b010, 4'b1100, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b011, 4'b1101, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b100, 4'b0011, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b101, 4'b0101, 0);
        rule(2'b10, 0, 0, 0, 7'b0100000, 0, 3'b101, 4'b0111, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b110, 4'b0001, 0);
        rule(2'b10, 0, 0, 0, 7'b0000000, 0, 3'b111, 4'b0000, 0);
        rule(2'b10, 0, 0, 0, 7'b0000001, 1, 3'b000, 4'b0010, 1);
        // I-type
        rule(2'b10, 0, 1, 1, 7'h0, 0, 3'b000, 4'b0010, 0);
        rule(2'b10, 0, 1, 1, 7'h0, 0, 3'b010, 4'b1100, 0);
        rule(2'b10, 0, 1, 1, 7'h0, 0, 3'b011, 4'b1101, 0);
        rule(2'b10, 0, 1, 1, 7'h0, 0, 3'b100, 4'b0011, 0);
        rule(2'b10, 0, 1, 1, 7'h0, 0, 3'b110, 4'b0001, 0);
        rule(2'b10, 0, 1, 1, 7'h0, 0, 3'b111, 4'b0000, 0);
        rule(2'b10, 0, 1, 0, 7'b0000000, 0, 3'b001, 4'b0100, 0);
        rule(2'b10, 0, 1, 0, 7'b0000000, 0, 3'b101, 4'b0101, 0);
        rule(2'b10, 0, 1, 0, 7'b0100000, 0, 3'b101, 4'b0111, 0);

        reset = 1'b1;
        valid2 = 1'b0;
        drive(2'b00, 1'b0, 7'h0, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check("rst_stall", stall1, 0);
        check("rst_done", done1, 0);
        check("rst_rsel", rsel1, 0);
        check("rst_kill", kill1, 0);
        check("rst_start", start1, 0);
        check("rst_mdu_op", mop1, 0);
        cyc();
        reset = 1'b0;

        // Directed decode
        cyc(); drive(2'b10, 1'b0, 7'b0000000, 3'b000, 1'b1, 1'b0); #2;
        check("r_add", op1, 4'b0010);
        check("r_add_ill", ill1, 0);
        cyc(); drive(2'b10, 1'b0, 7'b0100000, 3'b000, 1'b1, 1'b0); #2;
        check("r_sub", op1, 4'b0110);
        cyc(); drive(2'b10, 1'b0, 7'b0000000, 3'b101, 1'b1, 1'b0); #2;
        check("r_srl", op1, 4'b0101);
        cyc(); drive(2'b10, 1'b0, 7'b0100000, 3'b101, 1'b1, 1'b0); #2;
        check("r_sra", op1, 4'b0111);
        cyc(); drive(2'b10, 1'b1, 7'b0100000, 3'b000, 1'b1, 1'b0); #2;
        check("addi_f7alt", op1, 4'b0010);
        check("addi_f7alt_ill", ill1, 0);
        cyc(); drive(2'b10, 1'b1, 7'b0000000, 3'b000, 1'b1, 1'b0); #2;
        check("addi", op1, 4'b0010);

        // Illegal encodings
        cyc(); drive(2'b10, 1'b0, 7'b0000010, 3'b000, 1'b1, 1'b0); #2;
        check("bad_f7_ill", ill1, 1);
        check("bad_f7_op", op1, 4'b0000);
        check("bad_f7_start", start1, 0);
        cyc(); drive(2'b01, 1'b0, 7'b0000000, 3'b010, 1'b1, 1'b0); #2;
        check("bad_br_ill", ill1, 1);
        check("bad_br_op", op1, 4'b0000);
        check("bad_br_start", start1, 0);
        cyc(); drive(2'b10, 1'b0, 7'b0000001, 3'b000, 1'b0, 1'b0); valid2 = 1'b1; #2;
        check("nomdu_mul_ill", ill2, 1);
        check("nomdu_mul_op", op2, 4'b0000);
        check("nomdu_mul_start", start2, 0);
        check("nomdu_mul_stall", stall2, 0);
        cyc(); valid2 = 1'b0; #2;
        check("nomdu_ill_novalid", ill2, 0);
        check("nomdu_no_stall", stall2, 0);

        // Flush on the issue cycle never launches
        cyc(); drive(2'b10, 1'b0, 7'b0000001, 3'b000, 1'b1, 1'b1); #2;
        check("flush_issue_start", start1, 0);
        check("flush_issue_stall", stall1, 0);
        cyc(); drive(2'b00, 1'b0, 7'h0, 3'b000, 1'b0, 1'b0); #2;
        check("flush_issue_idle", stall1, 0);

        // MDU sequences
        mdu_run(3'b000, 0, 0, 0);
        mdu_run(3'b101, 0, 0, 0);
        mdu_run(3'b100, 10, 0, 0);
        mdu_run(3'b000, 0, 0, 0);
        mdu_run(3'b011, 0, 1, 0);
        mdu_run(3'b001, 0, 0, 1);
        mdu_run(3'b001, 0, 0, 0);

        // Async reset mid-BUSY, then full latency afterwards
        cyc(); drive(2'b10, 1'b0, 7'b0000001, 3'b110, 1'b1, 1'b0);
        repeat (3) cyc();
        #2;
        check("pre_rst_stall", stall1, 1);
        reset = 1'b1;
        #1;
        check("async_rst_stall", stall1, 0);
        check("async_rst_start", start1, 0);
        check("async_rst_mdu_op", mop1, 0);
        check("async_rst_done", done1, 0);
        valid_in = 1'b0;
        cyc();
        reset = 1'b0;
        mdu_run(3'b000, 0, 0, 0);

        // Randomized decode sweep; flush keeps the FSM idle
        for (int n = 0; n < 300; n++) begin
            cyc();
            sel = $urandom_range(0, 3);
            f7 = (sel == 0) ? 7'b0000000 : (sel == 1) ? 7'b0100000 :
                 (sel == 2) ? 7'b0000001 : 7'($urandom);
            drive(2'($urandom), 1'($urandom), f7, 3'($urandom), 1'($urandom), 1'b1);
            valid2 = 1'($urandom);
            #2;
            ref_decode(ALUOp, IsImm, Funct7, Funct3, 1'b1, eop1, ebad1);
            ref_decode(ALUOp, IsImm, Funct7, Funct3, 1'b0, eop2, ebad2);
            check("rnd_ill", ill1, valid_in & ebad1);
            check("rnd_ill_nomdu", ill2, valid2 & ebad2);
            if (valid_in) check("rnd_op", op1, eop1);
            if (valid2) check("rnd_op_nomdu", op2, eop2);
            check("rnd_start", start1, 0);
            check("rnd_start_nomdu", start2, 0);
        end
        flush = 1'b0;
        valid2 = 1'b0;

        // Randomized MDU ops with optional kill during BUSY
        for (int n = 0; n < 6; n++) begin
            logic [2:0] f3r;
            int unsigned lat, kat;
            f3r = 3'($urandom);
            lat = f3r[2] ? DIV_LAT : MUL_LAT;
            kat = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat) : 0;
            mdu_run(f3r, kat, 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
